// File: rtl/cache_fill_ctrl.sv
// Cache block fill controller: arbitrates D/I miss requests and streams
// one block of words from memory into the granted cache's data array.
module cache_fill_ctrl #(
    parameter int NUM_REQ = 2,
    parameter int WORDS   = 8,
    parameter int AWIDTH  = 16,
    parameter int DWIDTH  = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          miss_req,
    input  logic [NUM_REQ*AWIDTH-1:0]   miss_addr,
    output logic                        mem_rd_en,
    output logic [AWIDTH-1:0]           mem_addr,
    input  logic [DWIDTH-1:0]           mem_data,
    input  logic                        mem_data_valid,
    output logic [NUM_REQ-1:0]          grant,
    output logic [NUM_REQ-1:0]          fill_wen,
    output logic [$clog2(WORDS)-1:0]    fill_word_idx,
    output logic [DWIDTH-1:0]           fill_data,
    output logic [NUM_REQ-1:0]          fill_done,
    output logic                        busy
);

    localparam int IW  = $clog2(WORDS);
    localparam int CW  = IW + 1;
    localparam int OFS = IW + 1;

    localparam logic [CW-1:0]     WORDS_C  = CW'(WORDS);
    localparam logic [CW-1:0]     LAST_C   = CW'(WORDS - 1);
    localparam logic [AWIDTH-1:0] OFS_MASK = AWIDTH'((1 << OFS) - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [AWIDTH-1:0]   base_q, base_d;
    logic [CW-1:0]       ic_q, ic_d;
    logic [CW-1:0]       rc_q, rc_d;

    logic [NUM_REQ-1:0]  pick_oh;
    logic [AWIDTH-1:0]   pick_addr;
    logic                pick_found;

    // Fixed-priority pick of the lowest-indexed pending miss and its address.
    always_comb begin
        pick_oh    = '0;
        pick_addr  = '0;
        pick_found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (miss_req[i] && !pick_found) begin
                pick_found = 1'b1;
                pick_oh[i] = 1'b1;
                pick_addr  = miss_addr[i*AWIDTH +: AWIDTH];
            end
        end
    end

    // Next-state and output decode; issue and receive counters run independently.
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        base_d        = base_q;
        ic_d          = ic_q;
        rc_d          = rc_q;
        mem_rd_en     = 1'b0;
        mem_addr      = '0;
        fill_wen      = '0;
        fill_word_idx = '0;
        fill_data     = '0;
        fill_done     = '0;

        unique case (state_q)
            IDLE: begin
                if (pick_found) begin
                    grant_d = pick_oh;
                    base_d  = pick_addr & ~OFS_MASK;
                    ic_d    = '0;
                    rc_d    = '0;
                    state_d = FILL;
                end
            end
            FILL: begin
                fill_data = mem_data;
                if (ic_q != WORDS_C) begin
                    mem_rd_en = 1'b1;
                    mem_addr  = base_q + (AWIDTH'(ic_q) << 1);
                    ic_d      = ic_q + CW'(1);
                end
                if (mem_data_valid && (rc_q != WORDS_C)) begin
                    fill_wen      = grant_q;
                    fill_word_idx = rc_q[IW-1:0];
                    rc_d          = rc_q + CW'(1);
                    if (rc_q == LAST_C) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                fill_done = grant_q;
                grant_d   = '0;
                state_d   = IDLE;
            end
            default: begin
                grant_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    // State, grant, block base and counters; reset aborts any fill in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            base_q  <= '0;
            ic_q    <= '0;
            rc_q    <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            base_q  <= base_d;
            ic_q    <= ic_d;
            rc_q    <= rc_d;
        end
    end

    assign grant = grant_q;
    assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Scoreboard bench for cache_fill_ctrl: stimulus queues expected issues,
// writes and done pulses; a negedge monitor pops and compares them.
module tb_cache_fill_ctrl;

    localparam logic [15:0] KEY = 16'h5A3C;

    typedef struct { int inst; logic [1:0] g; logic [15:0] a; int c; } rd_t;
    typedef struct { int inst; logic [1:0] g; logic [2:0] i; logic [15:0] d; } wr_t;
    typedef struct { int inst; logic [1:0] g; int c; } dn_t;
    typedef struct { int due; logic [15:0] d; } pend_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  mr0 = '0, mr1 = '0;
    logic [31:0] ma0 = '0, ma1 = '0;
    logic        rd0, rd1;
    logic [15:0] ad0, ad1;
    logic [15:0] md0 = '0, md1 = '0;
    logic        mv0 = 1'b0, mv1 = 1'b0;
    logic [1:0]  g0, g1, we0, we1, dn0, dn1;
    logic [2:0]  ix0;
    logic [1:0]  ix1;
    logic [15:0] fd0, fd1;
    logic        bz0, bz1;

    int    cyc = 0;
    int    n_cmp = 0;
    int    n_bad = 0;
    int    wr_seen = 0;
    int    dn_seen = 0;
    rd_t   rd_q[$];
    wr_t   wr_q[$];
    dn_t   dn_q[$];
    pend_t p0[$], p1[$];
    pend_t pe0, pe1;
    int    last0 = -1, last1 = -1;
    int    lat0 = 3, lat1 = 2;
    int    d0, d1;
    bit    rnd0 = 1'b0;
    bit    spur1 = 1'b0;

    cache_fill_ctrl #(.NUM_REQ(2), .WORDS(8), .AWIDTH(16), .DWIDTH(16)) u0 (
        .clk(clk), .rst(rst), .miss_req(mr0), .miss_addr(ma0),
        .mem_rd_en(rd0), .mem_addr(ad0), .mem_data(md0),
        .mem_data_valid(mv0), .grant(g0), .fill_wen(we0),
        .fill_word_idx(ix0), .fill_data(fd0), .fill_done(dn0), .busy(bz0)
    );

    cache_fill_ctrl #(.NUM_REQ(2), .WORDS(4), .AWIDTH(16), .DWIDTH(16)) u1 (
        .clk(clk), .rst(rst), .miss_req(mr1), .miss_addr(ma1),
        .mem_rd_en(rd1), .mem_addr(ad1), .mem_data(md1),
        .mem_data_valid(mv1), .grant(g1), .fill_wen(we1),
        .fill_word_idx(ix1), .fill_data(fd1), .fill_done(dn1), .busy(bz1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic bad(input string nm, input logic [63:0] act);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got %0h want none (cycle %0d)", nm, act, cyc);
    endtask

    task automatic mon(input int inst, input logic r, input logic bz,
                       input logic rd, input logic [15:0] ad,
                       input logic [1:0] g, input logic [1:0] wen,
                       input logic [2:0] ix, input logic [15:0] dt,
                       input logic [1:0] dn);
        rd_t re;
        wr_t we;
        dn_t de;
        if (r) begin
            chk($sformatf("u%0d_rst_quiet", inst),
                {bz, rd, ad, g, wen, ix, dt, dn}, '0);
            return;
        end
        if (!bz)
            chk($sformatf("u%0d_idle_quiet", inst), {rd, g, wen, dn}, '0);
        if (rd) begin
            if (rd_q.size() == 0 || rd_q[0].inst != inst) begin
                bad($sformatf("u%0d_rd_unexpected", inst), ad);
            end else begin
                re = rd_q.pop_front();
                chk($sformatf("u%0d_rd_addr", inst), ad, re.a);
                chk($sformatf("u%0d_rd_grant", inst), g, re.g);
                if (re.c >= 0)
                    chk($sformatf("u%0d_rd_cycle", inst), cyc, re.c);
            end
        end
        if (|wen) begin
            if (wr_q.size() == 0 || wr_q[0].inst != inst) begin
                bad($sformatf("u%0d_wen_unexpected", inst), wen);
            end else begin
                we = wr_q.pop_front();
                wr_seen++;
                chk($sformatf("u%0d_wen", inst), wen, we.g);
                chk($sformatf("u%0d_wen_grant", inst), g, we.g);
                chk($sformatf("u%0d_word_idx", inst), ix, we.i);
                chk($sformatf("u%0d_fill_data", inst), dt, we.d);
            end
        end
        if (|dn) begin
            if (dn_q.size() == 0 || dn_q[0].inst != inst) begin
                bad($sformatf("u%0d_done_unexpected", inst), dn);
            end else begin
                de = dn_q.pop_front();
                dn_seen++;
                chk($sformatf("u%0d_fill_done", inst), dn, de.g);
                if (de.c >= 0)
                    chk($sformatf("u%0d_done_cycle", inst), cyc, de.c);
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0, rst, bz0, rd0, ad0, g0, we0, ix0, fd0, dn0);
        mon(1, rst, bz1, rd1, ad1, g1, we1, {1'b0, ix1}, fd1, dn1);
    end

    always @(negedge clk) begin
        if (!rst && rd0) begin
            d0 = cyc + (rnd0 ? int'($urandom_range(6, 1)) : lat0);
            if (d0 <= last0) d0 = last0 + 1;
            last0 = d0;
            p0.push_back('{d0, ad0 ^ KEY});
        end
        if (!rst && rd1) begin
            d1 = cyc + lat1;
            if (d1 <= last1) d1 = last1 + 1;
            last1 = d1;
            p1.push_back('{d1, ad1 ^ KEY});
        end
    end

    always @(posedge clk) begin
        #1;
        if (p0.size() > 0 && p0[0].due == cyc) begin
            pe0 = p0.pop_front();
            mv0 = 1'b1;
            md0 = pe0.d;
        end else begin
            mv0 = 1'b0;
            md0 = 16'hDEAD;
        end
        if (p1.size() > 0 && p1[0].due == cyc) begin
            pe1 = p1.pop_front();
            mv1 = 1'b1;
            md1 = pe1.d;
        end else if (spur1) begin
            spur1 = 1'b0;
            mv1 = 1'b1;
            md1 = 16'h1111;
        end else begin
            mv1 = 1'b0;
            md1 = 16'hBEEF;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_fill(input int inst, input int gi,
                               input logic [15:0] a, input int t0,
                               input int words, input int tdone);
        logic [15:0] base;
        logic [15:0] ea;
        logic [1:0]  g;
        g    = 2'b01 << gi;
        base = a & ~(16'(words * 2 - 1));
        for (int k = 0; k < words; k++) begin
            ea = base + 16'(2 * k);
            rd_q.push_back('{inst, g, ea, t0 + 1 + k});
            wr_q.push_back('{inst, g, 3'(k), ea ^ KEY});
        end
        dn_q.push_back('{inst, g, tdone});
    endtask

    task automatic wait_dn(input int n, input int budget);
        int k;
        k = 0;
        while (dn_seen < n && k < budget) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (dn_seen < n) bad("timeout_fill_done", dn_seen);
    endtask

    task automatic wait_wr(input int n, input int budget);
        int k;
        k = 0;
        while (wr_seen < n && k < budget) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (wr_seen < n) bad("timeout_fill_wen", wr_seen);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int nd;
        int nw;

        repeat (3) tick();
        rst = 1'b0;
        tick();

        // single D miss, latency 3; request dropped and address moved mid-fill
        lat0 = 3;
        t0 = cyc;
        mr0 = 2'b01;
        ma0 = {16'h0000, 16'h1236};
        expect_fill(0, 0, 16'h1236, t0, 8, t0 + 12);
        nd = dn_seen;
        tick();
        mr0 = 2'b00;
        ma0 = {16'h0000, 16'hBEEF};
        wait_dn(nd + 1, 60);
        @(negedge clk);
        chk("u0_busy_after_fill", {bz0, g0}, 3'b000);

        // simultaneous D and I misses: D first, I on the IDLE after D's DONE
        tick();
        t0 = cyc;
        mr0 = 2'b11;
        ma0 = {16'h4A5E, 16'h2010};
        expect_fill(0, 0, 16'h2010, t0, 8, t0 + 12);
        expect_fill(0, 1, 16'h4A5E, t0 + 13, 8, t0 + 25);
        nd = dn_seen;
        wait_dn(nd + 1, 60);
        tick();
        mr0 = 2'b10;
        wait_dn(nd + 2, 60);
        tick();
        mr0 = 2'b00;
        @(negedge clk);
        chk("u0_busy_after_pair", {bz0, g0}, 3'b000);

        // irregular return gaps, latency 1..6
        tick();
        rnd0 = 1'b1;
        t0 = cyc;
        mr0 = 2'b10;
        ma0 = {16'h7FF2, 16'h0000};
        expect_fill(0, 1, 16'h7FF2, t0, 8, -1);
        nd = dn_seen;
        tick();
        mr0 = 2'b00;
        wait_dn(nd + 1, 200);
        rnd0 = 1'b0;
        tick();

        // reset after four returns aborts the fill; late valids are ignored
        lat0 = 3;
        tick();
        t0 = cyc;
        nw = wr_seen;
        mr0 = 2'b01;
        ma0 = {16'h0000, 16'h3000};
        expect_fill(0, 0, 16'h3000, t0, 8, -1);
        tick();
        mr0 = 2'b00;
        wait_wr(nw + 4, 40);
        tick();
        rst = 1'b1;
        rd_q.delete();
        wr_q.delete();
        dn_q.delete();
        repeat (2) tick();
        rst = 1'b0;
        for (int k = 0; k < 20 && p0.size() != 0; k++) tick();
        chk("u0_late_valids_drained", p0.size(), 0);
        repeat (2) tick();
        t0 = cyc;
        mr0 = 2'b01;
        ma0 = {16'h0000, 16'h3456};
        expect_fill(0, 0, 16'h3456, t0, 8, t0 + 12);
        nd = dn_seen;
        tick();
        mr0 = 2'b00;
        wait_dn(nd + 1, 60);
        @(negedge clk);
        chk("u0_busy_after_reset_fill", {bz0, g0}, 3'b000);

        // WORDS=4 at the top of the address space; spurious valid in IDLE
        spur1 = 1'b1;
        repeat (3) tick();
        t0 = cyc;
        mr1 = 2'b01;
        ma1 = {16'h0000, 16'hFFFA};
        expect_fill(1, 0, 16'hFFFA, t0, 4, t0 + 7);
        nd = dn_seen;
        tick();
        mr1 = 2'b00;
        wait_dn(nd + 1, 40);
        @(negedge clk);
        chk("u1_busy_after_fill", {bz1, g1}, 3'b000);

        repeat (4) tick();
        chk("scoreboard_empty", rd_q.size() + wr_q.size() + dn_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cache_fill_ctrl.md
CACHE_FILL_CTRL -- requirements
Module: cache_fill_ctrl

Interface
REQ-001 Parameter NUM_REQ, default 2: number of cache requestors; index 0 is the D-cache, index 1 is the I-cache.
REQ-002 Parameter WORDS, default 8: 16-bit words per cache block; power of two, 2..64.
REQ-003 Parameter AWIDTH, default 16: byte address width.
REQ-004 Parameter DWIDTH, default 16: data word width.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 miss_req  input  NUM_REQ  level miss request per requestor.
REQ-008 miss_addr  input  NUM_REQ*AWIDTH  packed miss byte address; requestor i at [i*AWIDTH +: AWIDTH].
REQ-009 mem_rd_en  output  1  memory read issue strobe, one word per cycle.
REQ-010 mem_addr  output  AWIDTH  memory byte address for the current issue.
REQ-011 mem_data  input  DWIDTH  returned memory word.
REQ-012 mem_data_valid  input  1  mem_data is valid this cycle; returns arrive in issue order, any latency >= 1.
REQ-013 grant  output  NUM_REQ  one-hot; the requestor currently being filled.
REQ-014 fill_wen  output  NUM_REQ  one-hot data-array write strobe to the granted requestor.
REQ-015 fill_word_idx  output  log2(WORDS)  word index within the block for fill_data.
REQ-016 fill_data  output  DWIDTH  word to write; equals mem_data.
REQ-017 fill_done  output  NUM_REQ  one-cycle pulse to the granted requestor: write tag/valid, release stall.
REQ-018 busy  output  1  high in any state other than IDLE.

Function
REQ-019 FSM states SHALL be IDLE, FILL and DONE.
REQ-020 IDLE: if any miss_req bit is set, grant the lowest set index, latch its block base = miss_addr with the low log2(WORDS)+1 bits cleared, clear both counters, and go to FILL next cycle.
REQ-021 The requestor SHALL be chosen only in IDLE; grant stays constant from the FILL entry through the DONE cycle.
REQ-022 FILL: issue counter ic SHALL assert mem_rd_en with mem_addr = base + 2*ic on consecutive cycles, starting with the first FILL cycle, until WORDS issues have been made; no issue occurs after the WORDS-th.
REQ-023 FILL: each mem_data_valid SHALL assert fill_wen[grant] combinationally in the same cycle, with fill_word_idx = receive counter rc; rc then increments.
REQ-024 Issue and receive SHALL overlap; a valid may coincide with an issue in the same cycle.
REQ-025 When the WORDS-th valid is received, the next state SHALL be DONE.
REQ-026 DONE: fill_done[grant] SHALL pulse high for exactly one cycle; the next state is IDLE.
REQ-027 Back-to-back requests: a request still pending in IDLE after DONE SHALL be granted on that IDLE cycle; a fill therefore costs at least WORDS+3 cycles.
REQ-028 mem_data_valid in IDLE or DONE, or beyond WORDS returns, SHALL be ignored.
REQ-029 Deassertion of miss_req or a change of miss_addr during FILL SHALL NOT abort or redirect the fill.
REQ-030 Address arithmetic SHALL be modulo 2^AWIDTH; a block at the top of the address space issues without carry out.
REQ-031 mem_rd_en, fill_wen, fill_done and grant SHALL be low in IDLE.

Reset
REQ-032 While rst is high: state IDLE; counters, base and grant cleared; all outputs 0.
REQ-033 Reset asserted mid-FILL SHALL abort the fill immediately: no fill_done, and outstanding returns ignored.

Verification
REQ-034 Single D miss: miss_req=01, miss_addr[0]=0x1236, memory latency 3 -> mem_addr 0x1230..0x123E on 8 consecutive cycles; fill_wen[0] with idx 0..7; fill_done=01 in cycle 12 after grant; busy low afterwards.
REQ-035 Simultaneous misses: miss_req=11 -> D filled first (grant=01); I granted on the IDLE cycle after D's DONE; I base taken from its own address.
REQ-036 Irregular returns: valids gapped randomly at latency 1..6 -> fill_word_idx strictly 0..WORDS-1 in order; exactly WORDS fill_wen pulses.
REQ-037 Reset after 4 returns -> all outputs 0 within the reset cycle; late valids produce no fill_wen; a new miss then fills normally.
REQ-038 WORDS=4 with miss_addr 0xFFFA -> addresses 0xFFF8, 0xFFFA, 0xFFFC, 0xFFFE; a spurious valid in IDLE produces no write.
